// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus send sequencer feeding a UART transmitter one frame at a time.
// Define UART_TXBUF_GAP_EN to hold GAP_CYCLES idle clocks after every frame.
module uart_tx_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_done,
    output logic                   busy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYCLES < 1) begin : g_param_check
        $error("uart_tx_buffer: DEPTH must be a power of two >= 2 and GAP_CYCLES >= 1");
    end

`ifdef UART_TXBUF_GAP_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0] r_gap_cnt;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
`endif

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    logic          r_tx_send;
    logic          w_push;
    logic          w_pop;

    assign full     = (r_count == CNT_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign tx_send  = r_tx_send;
    assign busy     = (r_state != IDLE) || !empty;

    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    assign w_push = wr_en && !full;
    assign w_pop  = (r_state == LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (!empty) w_state_next = LOAD;
            LOAD: w_state_next = SEND;
            SEND: w_state_next = WAIT;
            WAIT: begin
                if (tx_done) begin
`ifdef UART_TXBUF_GAP_EN
                    w_state_next = GAP;
`else
                    w_state_next = IDLE;
`endif
                end
            end
`ifdef UART_TXBUF_GAP_EN
            GAP: if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_state_next = IDLE;
`endif
            default: w_state_next = IDLE;
        endcase
    end

`ifdef UART_TXBUF_GAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap_cnt <= '0;
        end else if (r_state != GAP) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
            r_tx_send  <= 1'b0;
        end else begin
            r_overflow <= wr_en && full;
            r_tx_send  <= (w_state_next == SEND);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO plus send sequencer sitting directly upstream of the UART transmitter.
- Accepts bytes from a host/bus at any rate and stores them.
- Presents bytes one at a time on the transmitter's dintx/send inputs, waiting for donetx before releasing the next byte.
- Decouples producer bursts from the serial baud rate.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- GAP_CYCLES, 16, idle clocks inserted between frames when UART_TXBUF_GAP_EN is defined; >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- wr_en  input  1  write strobe; one byte accepted per cycle when full=0.
- wr_data  input  8  byte to enqueue.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  one-cycle pulse when wr_en is asserted while full=1.
- tx_data  output  8  byte to transmitter (drives dintx).
- tx_send  output  1  one-cycle send pulse to transmitter (drives send).
- tx_done  input  1  one-cycle completion pulse from transmitter (donetx).
- busy  output  1  high when state != IDLE or empty=0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. With rst=0:
  - Pointers and count are 0; state is IDLE.
  - tx_data=8'h00, tx_send=0, overflow=0.
  - Consequently full=0, empty=1, busy=0.
  - Reset mid-frame drops all queued bytes and the in-flight byte. No tx_send is issued until new data is written after reset release.
- Storage: circular buffer with DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
  - full = (count==DEPTH); empty = (count==0). Both are decoded from registered count, not from next-state.
- Write:
  - wr_en sampled with full=0: store wr_data at wr_ptr, then wr_ptr++.
  - wr_en with full=1: byte dropped, pointers unchanged, overflow=1 for the following cycle.
  - Full status is judged on the registered value. A pop in the same cycle does not rescue a write made while full=1.
- Count update:
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
- FSM states: IDLE, LOAD, SEND, WAIT, GAP.
  - IDLE: if empty=0, go to LOAD.
  - LOAD: tx_data <= mem[rd_ptr]; rd_ptr++; count decremented (pop); go to SEND.
  - SEND: tx_send=1 for exactly this one cycle; go to WAIT.
  - WAIT: tx_data held stable. On tx_done=1, go to GAP if the feature is enabled, otherwise to IDLE.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- tx_send and tx_data are registered outputs.
- tx_data is held from LOAD until the next LOAD, including through IDLE.
- tx_done outside WAIT is ignored.
- Latency: wr_en into an empty idle buffer at edge N gives:
  - empty=0 after edge N;
  - LOAD at edge N+1;
  - tx_data valid and tx_send=1 after edge N+2.
- Back-to-back: tx_done at edge M (feature off) gives IDLE at M, LOAD at M+1, and the next tx_send high after edge M+2 if data is queued.
- Throughput: at most one frame in flight; never two tx_send pulses without an intervening tx_done.

Optional Feature:
- Macro: UART_TXBUF_GAP_EN.
- Defined:
  - WAIT goes to GAP on tx_done.
  - A $clog2(GAP_CYCLES+1)-bit counter holds the FSM in GAP for exactly GAP_CYCLES cycles before IDLE, giving a guaranteed extra stop-bit idle time for slow receivers.
  - busy stays high during GAP.
  - Reset clears the counter.
- Undefined:
  - The GAP state and counter are not present.
  - WAIT goes directly to IDLE on tx_done.

Test Plan:
- Single byte: reset, write 8'hA5 at edge N → tx_data=8'hA5 with tx_send=1 for exactly one cycle after edge N+2. Pulse tx_done 100 cycles later → busy=0 and empty=1 two cycles after (feature off).
- Burst order: write 8'h01..8'h05 on consecutive cycles, then answer each tx_send with tx_done 20 cycles later → tx_data sequence 01,02,03,04,05 with exactly five tx_send pulses; count returns to 0.
- Full/overflow (DEPTH=16): hold tx_done low and write 18 bytes → one byte in flight, FIFO fills. full=1 at count=16; the later extra write pulses overflow once and its byte is never transmitted. Subsequent tx_done pulses deliver the 17 accepted bytes in order.
- Pointer wrap: stream 40 incrementing bytes through DEPTH=16 while responding to tx_done → all 40 are transmitted in order with no duplicates or skips.
- Reset mid-operation: queue 6 bytes and pull rst low during WAIT → outputs return to reset values asynchronously. No tx_send after release until a new write; a new write of 8'h3C is the next byte transmitted.
- Gap (UART_TXBUF_GAP_EN, GAP_CYCLES=16): two queued bytes, tx_done at edge M → second tx_send occurs after edge M+18 instead of M+2.
